rs_15_11_encoder: RTL and testbench

Systematic RS(15,11) encoder over GF(16): the transmit-side counterpart of the syndrome/decoder chain. It accepts 11 4-bit message symbols, passes them through unchanged, and then appends 4 parity symbols computed by a generator-polynomial LFSR. A codeword emitted by this block yields all-zero syndromes S1..S4 in the decoder's syndrome cells.

---
 rtl/rs_15_11_encoder_pkg.sv | 42 ++++
 rtl/rs_15_11_encoder_if.sv | 34 +++
 rtl/rs_15_11_encoder_gf16_const_mult.sv | 14 +
 rtl/rs_15_11_encoder.sv | 95 +++++++++
 tb/tb_rs_15_11_encoder.sv | 267 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/rs_15_11_encoder_pkg.sv
// Shared RS(15,11) constants over GF(16), poly x^4+x+1.
// Generator g(x) = (x+a)(x+a^2)(x+a^3)(x+a^4), a = 4'h2.
package rs_pkg;

    localparam int N     = 15;
    localparam int K     = 11;
    localparam int NPAR  = 4;
    localparam int SYM_W = 4;

    localparam logic [SYM_W-1:0] G3 = 4'hD;
    localparam logic [SYM_W-1:0] G2 = 4'hC;
    localparam logic [SYM_W-1:0] G1 = 4'h8;
    localparam logic [SYM_W-1:0] G0 = 4'h7;

    typedef enum logic {
        DATA,
        PARITY
    } phase_e;

    function automatic logic [SYM_W-1:0] gf16_xtime(
        input logic [SYM_W-1:0] a
    );
        return {a[2:0], 1'b0} ^ (a[3] ? 4'h3 : 4'h0);
    endfunction

    // Constant operand folds this into a pure XOR network.
    function automatic logic [SYM_W-1:0] gf16_mul_const(
        input logic [SYM_W-1:0] a,
        input logic [SYM_W-1:0] c
    );
        logic [SYM_W-1:0] acc;
        logic [SYM_W-1:0] sh;
        acc = '0;
        sh  = a;
        for (int i = 0; i < SYM_W; i++) begin
            if (c[i]) acc = acc ^ sh;
            sh = gf16_xtime(sh);
        end
        return acc;
    endfunction

endpackage

// File: rtl/rs_15_11_encoder_if.sv
// Symbol stream bundle for the RS(15,11) encoder.
// master drives message symbols and OUT_READY; slave is the encoder.
interface rs_15_11_encoder_if;
    import rs_pkg::*;

    logic [SYM_W-1:0] IN_SERIAL;
    logic             IN_VALID;
    logic             IN_READY;
    logic [SYM_W-1:0] OUT_SERIAL;
    logic             OUT_VALID;
    logic             OUT_READY;
    logic             OUT_LAST;

    modport master (
        output IN_SERIAL,
        output IN_VALID,
        output OUT_READY,
        input  IN_READY,
        input  OUT_SERIAL,
        input  OUT_VALID,
        input  OUT_LAST
    );

    modport slave (
        input  IN_SERIAL,
        input  IN_VALID,
        input  OUT_READY,
        output IN_READY,
        output OUT_SERIAL,
        output OUT_VALID,
        output OUT_LAST
    );

endinterface

// File: rtl/rs_15_11_encoder_gf16_const_mult.sv
// GF(16) multiply by a fixed constant C.
// Used for the generator taps on the LFSR feedback symbol.
module gf16_const_mult
    import rs_pkg::*;
#(
    parameter logic [SYM_W-1:0] C = 4'h1
) (
    input  logic [SYM_W-1:0] din,
    output logic [SYM_W-1:0] dout
);

    assign dout = gf16_mul_const(din, C);

endmodule

// File: rtl/rs_15_11_encoder.sv
// Systematic RS(15,11) encoder: 11 data symbols pass through,
// then 4 parity symbols shift out of the generator LFSR.
module rs_15_11_encoder
    import rs_pkg::*;
(
    input logic          CLK,
    input logic          RESET_GLOBAL,
    rs_15_11_encoder_if.slave bus
);

    localparam logic [3:0] LAST_DATA = 4'(K - 1);
    localparam logic [3:0] LAST_SYM  = 4'(N - 1);

    phase_e           phase;
    logic [3:0]       cnt;
    logic [SYM_W-1:0] r3, r2, r1, r0;
    logic [SYM_W-1:0] out_sym;
    logic             out_vld;
    logic             out_lst;

    logic             free;
    logic             in_rdy;
    logic [SYM_W-1:0] fb;
    logic [SYM_W-1:0] fb_g3, fb_g2, fb_g1, fb_g0;

    // The output slot is free when empty or being drained this cycle.
    assign free   = !out_vld || bus.OUT_READY;
    assign in_rdy = (phase == DATA) && free;
    assign fb     = bus.IN_SERIAL ^ r3;

    assign bus.IN_READY   = in_rdy;
    assign bus.OUT_SERIAL = out_sym;
    assign bus.OUT_VALID  = out_vld;
    assign bus.OUT_LAST   = out_lst;

    gf16_const_mult #(.C(G3)) u_g3 (.din(fb), .dout(fb_g3));
    gf16_const_mult #(.C(G2)) u_g2 (.din(fb), .dout(fb_g2));
    gf16_const_mult #(.C(G1)) u_g1 (.din(fb), .dout(fb_g1));
    gf16_const_mult #(.C(G0)) u_g0 (.din(fb), .dout(fb_g0));

    // Phase FSM, LFSR update/shift-out and output register.
    always_ff @(posedge CLK or negedge RESET_GLOBAL) begin
        if (!RESET_GLOBAL) begin
            phase   <= DATA;
            cnt     <= '0;
            r3      <= '0;
            r2      <= '0;
            r1      <= '0;
            r0      <= '0;
            out_sym <= '0;
            out_vld <= 1'b0;
            out_lst <= 1'b0;
        end else if (free) begin
            unique case (phase)
                DATA: begin
                    if (bus.IN_VALID) begin
                        r3      <= r2 ^ fb_g3;
                        r2      <= r1 ^ fb_g2;
                        r1      <= r0 ^ fb_g1;
                        r0      <= fb_g0;
                        out_sym <= bus.IN_SERIAL;
                        out_vld <= 1'b1;
                        out_lst <= 1'b0;
                        cnt     <= cnt + 4'd1;
                        if (cnt == LAST_DATA) phase <= PARITY;
                    end else begin
                        out_vld <= 1'b0;
                        out_lst <= 1'b0;
                    end
                end
                PARITY: begin
                    out_sym <= r3;
                    out_vld <= 1'b1;
                    if (cnt == LAST_SYM) begin
                        out_lst <= 1'b1;
                        cnt     <= '0;
                        r3      <= '0;
                        r2      <= '0;
                        r1      <= '0;
                        r0      <= '0;
                        phase   <= DATA;
                    end else begin
                        out_lst <= 1'b0;
                        cnt     <= cnt + 4'd1;
                        r3      <= r2;
                        r2      <= r1;
                        r1      <= r0;
                        r0      <= '0;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rs_15_11_encoder.sv
// Scoreboard bench for rs_15_11_encoder: directed codewords,
// random stalls, mid-parity backpressure and async reset.
module tb_rs_15_11_encoder;

    logic CLK;
    logic RESET_GLOBAL;

    rs_15_11_encoder_if bus ();

    rs_15_11_encoder dut (
        .CLK          (CLK),
        .RESET_GLOBAL (RESET_GLOBAL),
        .bus          (bus)
    );

    typedef struct {
        logic [3:0] sym;
        logic       last;
        bit         chk;
    } exp_t;

    exp_t       q[$];
    int         asserts;
    int         fails;
    int         pos;
    logic [3:0] cw[15];
    bit         mon_en;
    bit         held;
    logic [5:0] held_v;
    int         rmode;
    bit         stall_done;
    bit         cnt_en;
    int         lowcnt;

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    function automatic logic [3:0] gmul(logic [3:0] a, logic [3:0] b);
        logic [6:0] p;
        p = '0;
        for (int i = 0; i < 4; i++)
            if (b[i]) p = p ^ (7'(a) << i);
        for (int i = 6; i >= 4; i--)
            if (p[i]) p = p ^ (7'b0010011 << (i - 4));
        return p[3:0];
    endfunction

    task automatic check(input string name, input logic [7:0] act,
                         input logic [7:0] req);
        asserts++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got %h, expected %h at %0t",
                     name, act, req, $time);
        end
    endtask

    // Monitor: pops the scoreboard on every output transfer.
    initial begin
        logic [3:0] s;
        logic [3:0] root;
        exp_t       e;
        forever begin
            @(negedge CLK);
            #4;
            if (mon_en) begin
                if (held)
                    check("stall_hold",
                          {2'b0, bus.OUT_SERIAL, bus.OUT_VALID,
                           bus.OUT_LAST},
                          {2'b0, held_v});
                held   = bus.OUT_VALID && !bus.OUT_READY;
                held_v = {bus.OUT_SERIAL, bus.OUT_VALID, bus.OUT_LAST};
                if (bus.OUT_VALID && bus.OUT_READY) begin
                    if (q.size() == 0) begin
                        check("unexpected_out", 8'h1, 8'h0);
                    end else begin
                        e = q.pop_front();
                        if (e.chk)
                            check("out_sym", 8'(bus.OUT_SERIAL),
                                  8'(e.sym));
                        check("out_last", 8'(bus.OUT_LAST),
                              8'(e.last));
                    end
                    if (pos < 15) cw[pos] = bus.OUT_SERIAL;
                    pos++;
                    if (bus.OUT_LAST) begin
                        if (pos == 15) begin
                            root = 4'h2;
                            for (int i = 1; i <= 4; i++) begin
                                s = '0;
                                for (int j = 0; j < 15; j++)
                                    s = gmul(s, root) ^ cw[j];
                                check($sformatf("syndrome_S%0d", i),
                                      8'(s), 8'h00);
                                root = gmul(root, 4'h2);
                            end
                        end
                        pos = 0;
                    end
                end
            end
        end
    end

    // OUT_READY driver: always-on, random, or one 5-cycle stall.
    initial begin
        forever begin
            @(negedge CLK);
            case (rmode)
                1: bus.OUT_READY = ($urandom_range(0, 3) != 0);
                2: begin
                    if (pos == 12 && !stall_done) begin
                        bus.OUT_READY = 1'b0;
                        repeat (4) @(negedge CLK);
                        #4;
                        check("stall_p2_valid", 8'(bus.OUT_VALID), 8'h1);
                        check("stall_p2_value", 8'(bus.OUT_SERIAL),
                              8'h0C);
                        stall_done = 1'b1;
                    end else begin
                        bus.OUT_READY = 1'b1;
                    end
                end
                default: bus.OUT_READY = 1'b1;
            endcase
        end
    end

    // IN_READY low-cycle counter for the back-to-back codeword.
    initial begin
        forever begin
            @(negedge CLK);
            #4;
            if (cnt_en && !bus.IN_READY) lowcnt++;
        end
    end

    task automatic send(input logic [3:0] s, input bit gaps);
        int n;
        if (gaps) begin
            repeat ($urandom_range(0, 2)) begin
                @(negedge CLK);
                bus.IN_VALID  = 1'b0;
                bus.IN_SERIAL = 4'($urandom);
            end
        end
        @(negedge CLK);
        bus.IN_VALID  = 1'b1;
        bus.IN_SERIAL = s;
        n = 0;
        #4;
        while (!bus.IN_READY && n < 200) begin
            @(negedge CLK);
            #4;
            n++;
        end
        if (n >= 200) check("in_ready_timeout", 8'h1, 8'h0);
    endtask

    task automatic send_msg(input logic [43:0] msg, input logic [15:0] par,
                            input bit pchk, input bit gaps);
        exp_t e;
        for (int i = 0; i < 11; i++) begin
            e.sym  = msg[43 - 4*i -: 4];
            e.last = 1'b0;
            e.chk  = 1'b1;
            q.push_back(e);
        end
        for (int i = 0; i < 4; i++) begin
            e.sym  = par[15 - 4*i -: 4];
            e.last = (i == 3);
            e.chk  = pchk;
            q.push_back(e);
        end
        for (int i = 0; i < 11; i++) send(msg[43 - 4*i -: 4], gaps);
        @(negedge CLK);
        bus.IN_VALID  = 1'b0;
        bus.IN_SERIAL = 4'($urandom);
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((q.size() != 0 || bus.OUT_VALID) && n < 2000) begin
            @(negedge CLK);
            n++;
        end
        if (n >= 2000) check("drain_timeout", 8'h1, 8'h0);
    endtask

    initial begin
        asserts       = 0;
        fails         = 0;
        pos           = 0;
        mon_en        = 1'b0;
        held          = 1'b0;
        held_v        = '0;
        rmode         = 0;
        stall_done    = 1'b0;
        cnt_en        = 1'b0;
        lowcnt        = 0;
        bus.IN_VALID  = 1'b0;
        bus.IN_SERIAL = 4'h0;
        bus.OUT_READY = 1'b0;
        RESET_GLOBAL  = 1'b0;
        #1;
        check("rst_out_valid", 8'(bus.OUT_VALID), 8'h0);
        check("rst_out_serial", 8'(bus.OUT_SERIAL), 8'h0);
        check("rst_out_last", 8'(bus.OUT_LAST), 8'h0);
        check("rst_in_ready", 8'(bus.IN_READY), 8'h1);
        @(negedge CLK);
        #2;
        RESET_GLOBAL = 1'b1;
        mon_en = 1'b1;

        cnt_en = 1'b1;
        send_msg(44'h0, 16'h0000, 1'b1, 1'b0);
        drain();
        cnt_en = 1'b0;
        check("in_ready_low_cycles", 8'(lowcnt), 8'd4);

        send_msg(44'h1, 16'hDC87, 1'b1, 1'b0);
        drain();

        rmode = 1;
        send_msg(44'h10, 16'h2B55, 1'b1, 1'b1);
        drain();

        rmode = 2;
        stall_done = 1'b0;
        send_msg(44'h1, 16'hDC87, 1'b1, 1'b0);
        drain();
        check("stall_happened", 8'(stall_done), 8'h1);

        rmode = 0;
        mon_en = 1'b0;
        for (int i = 0; i < 6; i++) send(4'($urandom), 1'b0);
        @(negedge CLK);
        RESET_GLOBAL = 1'b0;
        bus.IN_VALID = 1'b0;
        #1;
        check("arst_out_valid", 8'(bus.OUT_VALID), 8'h0);
        check("arst_out_serial", 8'(bus.OUT_SERIAL), 8'h0);
        check("arst_out_last", 8'(bus.OUT_LAST), 8'h0);
        check("arst_in_ready", 8'(bus.IN_READY), 8'h1);
        #2;
        RESET_GLOBAL = 1'b1;
        q.delete();
        pos    = 0;
        held   = 1'b0;
        mon_en = 1'b1;
        send_msg(44'h1, 16'hDC87, 1'b1, 1'b0);
        drain();

        rmode = 1;
        for (int k = 0; k < 1000; k++)
            send_msg({12'($urandom), 32'($urandom)}, 16'h0, 1'b0, 1'b1);
        drain();
        check("queue_empty", 8'(q.size()), 8'h0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 asserts, fails);
        $finish;
    end

endmodule
